// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package mmio_pkg;

    localparam logic [31:0] DEF_TXDATA_ADDR = 32'h0000_0400;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_0404;

    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_ACTIVE  = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view seen by memory-mapped peripherals.
interface mmio_uart_tx_if;

    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        io_sel;
    logic [31:0] io_rdata;

    modport master (
        output MemWrite, DataAdr, WriteData,
        input  io_sel, io_rdata
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData,
        output io_sel, io_rdata
    );

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// First-word fall-through synchronous FIFO with wrap-bit pointers.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Flags come from the registered pointers, so a push while full is dropped even if a pop lands in the same cycle.
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty   = (wptr == rptr);
    assign count   = wptr - rptr;
    assign dout    = mem[rptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: address decode, status register and 8N1 serialiser.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] TXDATA_ADDR  = DEF_TXDATA_ADDR,
    parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    mmio_uart_tx_if.slave       bus,
    output logic                tx,
    output logic                busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    logic          sel_tx;
    logic          sel_st;
    logic          push;
    logic          ovf_clr;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_dout;
    logic          ovf_q;
    logic [31:0]   status;
    logic          unused_wdata;

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_d;
    logic          baud_last;

    assign sel_tx       = (bus.DataAdr == TXDATA_ADDR);
    assign sel_st       = (bus.DataAdr == STATUS_ADDR);
    assign push         = enable && bus.MemWrite && sel_tx;
    assign ovf_clr      = enable && bus.MemWrite && sel_st && bus.WriteData[ST_OVF];
    assign unused_wdata = ^bus.WriteData[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.WriteData[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset)                 ovf_q <= 1'b0;
        else if (push && fifo_full) ovf_q <= 1'b1;
        else if (ovf_clr)          ovf_q <= 1'b0;
    end

    always_comb begin
        status                      = '0;
        status[ST_FULL]             = fifo_full;
        status[ST_EMPTY]            = fifo_empty;
        status[ST_ACTIVE]           = (state_q != IDLE);
        status[ST_OVF]              = ovf_q;
        status[ST_CNT_LSB +: CW]    = fifo_count;
    end

    assign bus.io_sel   = sel_tx || sel_st;
    assign bus.io_rdata = sel_st ? status : '0;

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx and busy are registered from the current state, so both trail the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            busy    <= !fifo_empty || (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic tx;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TXDATA_ADDR  (32'h0000_0400),
        .STATUS_ADDR  (32'h0000_0404)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus),
        .tx     (tx),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = a;
        bus.WriteData = d;
        tick();
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        bus.DataAdr = 32'h0000_0404;
        #1;
        chk(tag, bus.io_rdata, exp);
    endtask

    // Starts at frame sample k0 (k=0 is the first cycle tx is low) and ends on the last stop-bit cycle.
    task automatic check_frame(input logic [7:0] b, input int unsigned k0);
        logic e;
        for (int unsigned k = k0; k < 10 * CPB; k++) begin
            if (k != k0) tick();
            if (k < CPB)           e = 1'b0;
            else if (k < 9 * CPB)  e = b[(k - CPB) / CPB];
            else                   e = 1'b1;
            chk($sformatf("frame_%h_k%0d", b, k), {31'b0, tx}, {31'b0, e});
        end
    endtask

    initial begin
        logic [7:0] bytes3 [5];
        int         glitches;

        reset         = 1'b1;
        enable        = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
        bus.WriteData = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk_status("rst_status", 32'h0000_0002);
        chk("rst_sel_status", {31'b0, bus.io_sel}, 32'd1);

        // single frame, upper data bits ignored
        bus_write(32'h0000_0400, 32'hFFFF_FF55);
        chk_status("t1_count1", 32'h0000_0010);
        chk("t1_tx_n", {31'b0, tx}, 32'd1);
        tick();
        chk("t1_tx_n1", {31'b0, tx}, 32'd1);
        chk("t1_busy_n1", {31'b0, busy}, 32'd1);
        tick();
        check_frame(8'h55, 0);
        chk("t1_busy_last_stop", {31'b0, busy}, 32'd1);
        tick();
        chk("t1_busy_drop", {31'b0, busy}, 32'd0);
        chk("t1_tx_idle", {31'b0, tx}, 32'd1);

        // back-to-back frames; second push coincides with the first pop
        bus_write(32'h0000_0400, 32'h0000_00A1);
        chk_status("t2_after_w1", 32'h0000_0010);
        bus_write(32'h0000_0400, 32'h0000_00B2);
        chk_status("t2_after_w2", 32'h0000_0014);
        tick();
        check_frame(8'hA1, 0);
        tick();
        chk("t2_gap_high", {31'b0, tx}, 32'd1);
        chk("t2_gap_busy", {31'b0, busy}, 32'd1);
        tick();
        check_frame(8'hB2, 0);
        tick();
        chk("t2_busy_drop", {31'b0, busy}, 32'd0);
        chk_status("t2_status_end", 32'h0000_0002);

        // overflow: six writes into a 4-deep FIFO
        bytes3[0] = 8'h11; bytes3[1] = 8'h22; bytes3[2] = 8'h33;
        bytes3[3] = 8'h44; bytes3[4] = 8'h55;
        bus_write(32'h0000_0400, 32'h0000_0011);
        chk_status("t3_w1", 32'h0000_0010);
        bus_write(32'h0000_0400, 32'h0000_0022);
        chk_status("t3_w2", 32'h0000_0014);
        bus_write(32'h0000_0400, 32'h0000_0033);
        chk_status("t3_w3", 32'h0000_0024);
        bus_write(32'h0000_0400, 32'h0000_0044);
        chk_status("t3_w4", 32'h0000_0034);
        bus_write(32'h0000_0400, 32'h0000_0055);
        chk_status("t3_w5_full", 32'h0000_0045);
        bus_write(32'h0000_0400, 32'h0000_0066);
        chk_status("t3_w6_ovf", 32'h0000_004D);
        check_frame(bytes3[0], 3);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("t3_gap%0d", i), {31'b0, tx}, 32'd1);
            tick();
            check_frame(bytes3[i], 0);
        end
        tick();
        chk("t3_busy_drop", {31'b0, busy}, 32'd0);
        chk_status("t3_ovf_sticky", 32'h0000_000A);
        bus_write(32'h0000_0404, 32'h0000_0004);
        chk_status("t3_clr_wrong_bit", 32'h0000_000A);
        bus_write(32'h0000_0404, 32'h0000_0008);
        chk_status("t3_ovf_cleared", 32'h0000_0002);

        // reset in the middle of data bit 3 with another byte queued
        bus_write(32'h0000_0400, 32'h0000_00C3);
        bus_write(32'h0000_0400, 32'h0000_005A);
        for (int i = 0; i < 17; i++) tick();
        chk("t4_bit3_low", {31'b0, tx}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_tx_high", {31'b0, tx}, 32'd1);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        chk_status("t4_status", 32'h0000_0002);
        glitches = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) glitches++;
        end
        chk("t4_no_frames", glitches, 32'd0);

        // enable low: store ignored, in-flight frame completes
        bus_write(32'h0000_0400, 32'h0000_000F);
        enable = 1'b0;
        bus_write(32'h0000_0400, 32'h0000_0077);
        chk_status("t5_no_push", 32'h0000_0006);
        tick();
        check_frame(8'h0F, 0);
        tick();
        chk("t5_busy_drop", {31'b0, busy}, 32'd0);
        chk_status("t5_status", 32'h0000_0002);
        enable = 1'b1;

        // address decode
        bus.DataAdr = 32'h0000_0010;
        #1;
        chk("t6_sel_other", {31'b0, bus.io_sel}, 32'd0);
        chk("t6_rdata_other", bus.io_rdata, 32'h0);
        bus.DataAdr = 32'h0000_0400;
        #1;
        chk("t6_sel_txdata", {31'b0, bus.io_sel}, 32'd1);
        chk("t6_rdata_txdata", bus.io_rdata, 32'h0);
        bus.DataAdr = 32'h1000_0404;
        #1;
        chk("t6_sel_alias", {31'b0, bus.io_sel}, 32'd0);
        bus_write(32'h0000_0010, 32'h0000_00AB);
        chk_status("t6_store_other", 32'h0000_0002);
        tick();
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_tx", {31'b0, tx}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
